pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/riscv_pipe_pkg.sv | 12 +
 rtl/pipe_stage_reg.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the pipeline stage registers.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with flush, stall and bubble insertion.
// Optional skid entry selected by PIPE_STAGE_SKID_BUFFER_EN (registered in_ready_o).
module pipe_stage_reg
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [DATA_W-1:0] BUBBLE_INSTR = DATA_W'(NOP_INSTR)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] addr_o
);

  stage_state_t      state;
  logic              out_valid_q;
  logic [DATA_W-1:0] main_instr;
  logic [ADDR_W-1:0] main_addr;
  logic              dn_rdy;
  logic              in_fire;
  logic              out_fire;

  assign dn_rdy      = out_ready_i & ~stall_i;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_q & dn_rdy;
  assign out_valid_o = out_valid_q;

  // Payload registers keep stale data when empty; the bubble is muxed in here.
  assign instr_o = out_valid_q ? main_instr : BUBBLE_INSTR;
  assign addr_o  = out_valid_q ? main_addr  : '0;

`ifdef PIPE_STAGE_SKID_BUFFER_EN

  logic [DATA_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_addr;
  logic              ready_q;

  assign in_ready_o = ready_q;

  // ready_q tracks "next state is not SKID", so it never depends on this cycle's downstream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      main_instr  <= '0;
      main_addr   <= '0;
      skid_instr  <= '0;
      skid_addr   <= '0;
    end else if (flush_i) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          ready_q <= 1'b1;
          if (in_fire) begin
            main_instr  <= instr_i;
            main_addr   <= addr_i;
            out_valid_q <= 1'b1;
            state       <= FULL;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_instr <= instr_i;
            main_addr  <= addr_i;
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end else if (in_fire) begin
            skid_instr <= instr_i;
            skid_addr  <= addr_i;
            ready_q    <= 1'b0;
            state      <= SKID;
          end
        end
        SKID: begin
          if (out_fire) begin
            main_instr <= skid_instr;
            main_addr  <= skid_addr;
            ready_q    <= 1'b1;
            state      <= FULL;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          state       <= EMPTY;
        end
      endcase
    end
  end

`else

  logic rdy_en;

  // rdy_en holds in_ready_o low during reset and for the first edge after release.
  assign in_ready_o = rdy_en & (~out_valid_q | dn_rdy);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      rdy_en      <= 1'b0;
      main_instr  <= '0;
      main_addr   <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (flush_i) begin
        state       <= EMPTY;
        out_valid_q <= 1'b0;
      end else begin
        unique case (state)
          EMPTY: begin
            if (in_fire) begin
              main_instr  <= instr_i;
              main_addr   <= addr_i;
              out_valid_q <= 1'b1;
              state       <= FULL;
            end
          end
          FULL: begin
            // Without a skid entry an input transfer here implies an output transfer.
            if (in_fire) begin
              main_instr <= instr_i;
              main_addr  <= addr_i;
            end else if (out_fire) begin
              out_valid_q <= 1'b0;
              state       <= EMPTY;
            end
          end
          default: begin
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end
        endcase
      end
    end
  end

`endif

endmodule
